// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit: sequences IF/ID/EX/MEM/WB and drives
// datapath latch enables, memory strobes and mux selects from the current state.
module multicycle_control_fsm #(
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       halt_req,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       mdr_write,
    output logic       pc_write,
    output logic       rf_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       is_halted,
    output logic [2:0] state
);
    // state | meaning
    // IF    | fetch instruction, wait for memory
    // ID    | decode, latch A/B, compute branch/JAL target
    // EX    | execute / address calc / branch resolve
    // MEM   | data memory access, wait for memory
    // WB    | register-file write-back, PC+4
    // HALT  | ecall halt, parked until reset
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    state_t cur, nxt;
    logic   ready;
    logic   known;

    assign ready = MEM_WAIT ? mem_ready : 1'b1;
    assign known = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                   (opcode == OP_STORE) || (opcode == OP_BR) || (opcode == OP_JAL) ||
                   (opcode == OP_JALR);
    assign state = cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= S_IF;
        else       cur <= nxt;
    end

    always_comb begin
        nxt          = S_IF;
        ir_write     = 1'b0;
        ab_write     = 1'b0;
        aluout_write = 1'b0;
        mdr_write    = 1'b0;
        pc_write     = 1'b0;
        rf_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        pc_src       = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        wb_sel       = 2'b00;
        is_halted    = 1'b0;
        case (cur)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = ready;
                nxt      = ready ? S_ID : S_IF;
            end
            S_ID: begin
                ab_write     = 1'b1;
                aluout_write = 1'b1;
                alu_src_b    = 2'b01;
                if (opcode == OP_ECALL && halt_req) begin
                    nxt = S_HALT;
                end else if (!known) begin
                    // non-halting ecall and unknown opcodes just step the PC
                    pc_write = 1'b1;
                    nxt      = S_IF;
                end else begin
                    nxt = S_EX;
                end
            end
            S_EX: begin
                case (opcode)
                    OP_R, OP_I: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = (opcode == OP_I) ? 2'b01 : 2'b00;
                        alu_op       = 2'b10;
                        aluout_write = 1'b1;
                        nxt          = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = 2'b01;
                        aluout_write = 1'b1;
                        nxt          = S_MEM;
                    end
                    OP_BR: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b01;
                        pc_write  = 1'b1;
                        pc_src    = alu_bcond ? 2'b01 : 2'b00;
                    end
                    OP_JAL: begin
                        rf_write = 1'b1;
                        wb_sel   = 2'b10;
                        pc_write = 1'b1;
                        pc_src   = 2'b01;
                    end
                    OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b01;
                        rf_write  = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_src    = 2'b10;
                    end
                    default: nxt = S_IF;
                endcase
            end
            S_MEM: begin
                if (opcode == OP_LOAD) begin
                    mem_read  = 1'b1;
                    iord      = 1'b1;
                    mdr_write = ready;
                    nxt       = ready ? S_WB : S_MEM;
                end else if (opcode == OP_STORE) begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    pc_write  = ready;
                    nxt       = ready ? S_IF : S_MEM;
                end
            end
            S_WB: begin
                rf_write = 1'b1;
                wb_sel   = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                pc_write = 1'b1;
            end
            S_HALT: begin
                is_halted = 1'b1;
                nxt       = S_HALT;
            end
            default: nxt = S_IF;
        endcase
        // reset masks the combinational outputs so nothing strobes while held
        if (reset) begin
            nxt          = S_IF;
            ir_write     = 1'b0;
            ab_write     = 1'b0;
            aluout_write = 1'b0;
            mdr_write    = 1'b0;
            pc_write     = 1'b0;
            rf_write     = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            iord         = 1'b0;
            pc_src       = 2'b00;
            alu_src_a    = 1'b0;
            alu_src_b    = 2'b00;
            alu_op       = 2'b00;
            wb_sel       = 2'b00;
            is_halted    = 1'b0;
        end
    end
endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Parameter MEM_WAIT, default 1: 1 = honour mem_ready; 0 = mem_ready internally treated as 1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; forces state to IF immediately.
REQ-004 opcode  input  7  RISC-V opcode from instruction register output (bits [6:0]).
REQ-005 alu_bcond  input  1  branch condition from ALU; valid in EX for branch.
REQ-006 halt_req  input  1  ecall halt condition (x17==10), computed by datapath.
REQ-007 mem_ready  input  1  memory access completes this cycle.
REQ-008 ir_write, ab_write, aluout_write, mdr_write  output  1 each  datapath latch enables, including the A/B operand registers.
REQ-009 pc_write, rf_write, mem_read, mem_write  output  1 each  PC, register-file and memory strobes.
REQ-010 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 pc_src  output  2  next-PC select: 00 PC+4, 01 ALUOut, 10 ALU result.
REQ-012 alu_src_a  output  1  ALU operand A: 0 PC, 1 A register.
REQ-013 alu_src_b  output  2  ALU operand B: 00 B register, 01 immediate, 10 constant 4.
REQ-014 alu_op  output  2  00 add, 01 branch compare (funct3), 10 funct3/funct7 decoded.
REQ-015 wb_sel  output  2  RF write data: 00 ALUOut, 01 MDR, 10 PC+4.
REQ-016 is_halted  output  1  high in HALT.
REQ-017 state  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.

Function
REQ-018 Outputs are combinational from state, opcode, alu_bcond, halt_req, mem_ready; every output not specified for a state is 0.
REQ-019 IF: mem_read=1, iord=0; on mem_ready, ir_write=1 and next state ID; otherwise remain in IF with ir_write=0.
REQ-020 ID: ab_write=1, aluout_write=1, alu_src_a=0, alu_src_b=01, alu_op=00 (branch/JAL target into ALUOut).
REQ-021 ID next: ECALL (1110011) with halt_req -> HALT; ECALL without halt_req -> pc_write=1, pc_src=00, next IF; unrecognised opcode -> same as ECALL without halt; all other recognised opcodes -> EX.
REQ-022 EX R-type (0110011): alu_src_a=1, alu_src_b=00, alu_op=10, aluout_write=1 -> WB.
REQ-023 EX I-arith (0010011): alu_src_a=1, alu_src_b=01, alu_op=10, aluout_write=1 -> WB.
REQ-024 EX LOAD (0000011)/STORE (0100011): alu_src_a=1, alu_src_b=01, alu_op=00, aluout_write=1 -> MEM.
REQ-025 EX BRANCH (1100011): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write=1, pc_src=01 if alu_bcond else 00 -> IF.
REQ-026 EX JAL (1101111): rf_write=1, wb_sel=10, pc_write=1, pc_src=01 -> IF.
REQ-027 EX JALR (1100111): alu_src_a=1, alu_src_b=01, alu_op=00, rf_write=1, wb_sel=10, pc_write=1, pc_src=10 -> IF.
REQ-028 MEM LOAD: mem_read=1, iord=1; on mem_ready, mdr_write=1 -> WB; else stay.
REQ-029 MEM STORE: mem_write=1, iord=1; on mem_ready, pc_write=1, pc_src=00 -> IF; else stay with mem_write held.
REQ-030 WB: rf_write=1, wb_sel=01 for LOAD else 00, pc_write=1, pc_src=00 -> IF.
REQ-031 HALT: is_halted=1, all enables 0; stays until reset.
REQ-032 Latency with mem_ready always 1: R/I 4 cycles, LOAD 5, STORE 4, BRANCH/JAL/JALR 3, ECALL non-halt 2.
REQ-033 Unused state encodings 6-7 -> IF next cycle, all enables 0.

Reset
REQ-034 While reset high, state=IF and all enable outputs forced 0 (including mem_read), is_halted=0, selects 0.
REQ-035 Reset asserted mid-instruction (any state, including MEM with mem_write) aborts it; no pc_write/rf_write/mem_write occurs after assertion.
REQ-036 First rising edge after reset deassertion evaluates IF normally.

Verification
REQ-037 R-type, mem_ready=1 -> state 0,1,2,4,0; rf_write=1 and pc_write=1 only in WB with wb_sel=00.
REQ-038 LOAD, mem_ready low 3 cycles in MEM -> mem_read/iord=1 held 4 cycles, single mdr_write pulse, then WB wb_sel=01.
REQ-039 BRANCH alu_bcond=1 -> EX pc_src=01; alu_bcond=0 -> pc_src=00; both return to IF after 3 cycles.
REQ-040 ECALL halt_req=1 -> HALT from cycle 3, is_halted=1 persists 10+ cycles; reset returns state to 0.
REQ-041 STORE with reset asserted in MEM mid-wait -> mem_write drops same cycle, state=0, no pc_write.
REQ-042 MEM_WAIT=0, mem_ready tied 0 -> LOAD completes in 5 cycles.
